big_data_2d_sched: RTL

- Sequences periodic full-frame walks of a flattened SIZE_X×SIZE_Y int buffer for the DPI check bridge.
- Each period tick streams every element address (x, y, flat index) to the consumer over a valid/ready handshake.
- Counts completed frames and stops after REPEAT frames.
- Sits between the stimulus/timebase and the DPI bridge, which reads i/io at the issued index.

---
 rtl/big_data_2d_pkg.sv | 33 +++
 rtl/big_data_period_timer.sv | 32 +++
 rtl/big_data_2d_sched.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/big_data_2d_pkg.sv
// Shared defaults, scheduler state encoding and width helpers
// for the 2D frame-walk scheduler that feeds the DPI check bridge.
package big_data_2d_pkg;

    localparam int DEF_SIZE_X = 100;
    localparam int DEF_SIZE_Y = 10;
    localparam int DEF_PERIOD = 1000;
    localparam int DEF_REPEAT = 100000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_STREAM,
        S_DONE
    } sched_state_e;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    function automatic int x_w(input int sx);
        return clog2_min1(sx);
    endfunction

    function automatic int y_w(input int sy);
        return clog2_min1(sy);
    endfunction

    function automatic int f_w(input int sx, input int sy);
        return clog2_min1(sx * sy);
    endfunction

endpackage

// File: rtl/big_data_period_timer.sv
// Period counter: counts 0..PERIOD-1 while enabled, ticks on the last count.
// Ports: clk, rst_n, i_en (count), i_clr (to 0), o_tick (combinational).
module big_data_period_timer
    import big_data_2d_pkg::*;
#(
    parameter int PERIOD = DEF_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int C_W = clog2_min1(PERIOD);
    localparam logic [C_W-1:0] C_LAST = C_W'(PERIOD - 1);

    logic [C_W-1:0] r_cnt;

    assign o_tick = i_en && (r_cnt == C_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/big_data_2d_sched.sv
// Periodic raster walker over a SIZE_X x SIZE_Y buffer, issuing (x, y, flat)
// addresses over valid/ready, counting frames until REPEAT, then DONE.
// Ports: clk, rst_n, start, abort, addr_valid/ready, addr_x/y/flat,
// frame_start, frame_done, frames_done, busy, done,
// overrun_cnt (only with BIG_DATA_SCHED_OVERRUN_CNT_EN defined).
module big_data_2d_sched
    import big_data_2d_pkg::*;
#(
    parameter int SIZE_X = DEF_SIZE_X,
    parameter int SIZE_Y = DEF_SIZE_Y,
    parameter int PERIOD = DEF_PERIOD,
    parameter int REPEAT = DEF_REPEAT,
    localparam int X_W = x_w(SIZE_X),
    localparam int Y_W = y_w(SIZE_Y),
    localparam int F_W = f_w(SIZE_X, SIZE_Y)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           abort,
    output logic           addr_valid,
    input  logic           addr_ready,
    output logic [X_W-1:0] addr_x,
    output logic [Y_W-1:0] addr_y,
    output logic [F_W-1:0] addr_flat,
    output logic           frame_start,
    output logic           frame_done,
    output logic [31:0]    frames_done,
    output logic           busy,
    output logic           done
`ifdef BIG_DATA_SCHED_OVERRUN_CNT_EN
    ,
    output logic [15:0]    overrun_cnt
`endif
);

    localparam logic [X_W-1:0] X_LAST = X_W'(SIZE_X - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(SIZE_Y - 1);

    sched_state_e   r_state;
    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    logic [F_W-1:0] r_flat;
    logic           r_valid;
    logic           r_pending;
    logic           r_fstart;
    logic           r_fdone;
    logic [31:0]    r_frames;
    logic           r_busy;
    logic           r_done;

    logic w_tick;
    logic w_en;
    logic w_arm;
    logic w_accept;
    logic w_last;
    logic w_drop;

    assign w_en     = (r_state == S_WAIT) || (r_state == S_STREAM);
    assign w_arm    = start && !abort &&
                      ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_accept = r_valid && addr_ready;
    assign w_last   = (r_x == X_LAST) && (r_y == Y_LAST);
    // A tick is lost only while a frame is still issuing beats and one
    // frame is already queued.
    assign w_drop   = (r_state == S_STREAM) && r_valid && w_tick && r_pending;

    big_data_period_timer #(
        .PERIOD (PERIOD)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (w_en),
        .i_clr  (w_arm || abort),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_x       <= '0;
            r_y       <= '0;
            r_flat    <= '0;
            r_valid   <= 1'b0;
            r_pending <= 1'b0;
            r_fstart  <= 1'b0;
            r_fdone   <= 1'b0;
            r_frames  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else if (abort) begin
            r_state   <= S_IDLE;
            r_valid   <= 1'b0;
            r_pending <= 1'b0;
            r_fstart  <= 1'b0;
            r_fdone   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_fdone <= 1'b0;
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state   <= S_WAIT;
                        r_frames  <= '0;
                        r_pending <= 1'b0;
                        r_busy    <= 1'b1;
                        r_done    <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (w_tick) begin
                        r_state  <= S_STREAM;
                        r_x      <= '0;
                        r_y      <= '0;
                        r_flat   <= '0;
                        r_valid  <= 1'b1;
                        r_fstart <= 1'b1;
                    end
                end
                S_STREAM: begin
                    if (r_valid) begin
                        if (w_tick) r_pending <= 1'b1;
                        if (w_accept) begin
                            r_fstart <= 1'b0;
                            if (w_last) begin
                                r_valid  <= 1'b0;
                                r_fdone  <= 1'b1;
                                r_frames <= r_frames + 32'd1;
                            end else if (r_y == Y_LAST) begin
                                r_y    <= '0;
                                r_x    <= r_x + 1'b1;
                                r_flat <= r_flat + 1'b1;
                            end else begin
                                r_y    <= r_y + 1'b1;
                                r_flat <= r_flat + 1'b1;
                            end
                        end
                    end else begin
                        // Post-frame cycle: frame_done is out, decide what next.
                        if (r_frames == 32'(REPEAT)) begin
                            r_state   <= S_DONE;
                            r_pending <= 1'b0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                        end else if (r_pending || w_tick) begin
                            r_x       <= '0;
                            r_y       <= '0;
                            r_flat    <= '0;
                            r_valid   <= 1'b1;
                            r_fstart  <= 1'b1;
                            r_pending <= r_pending && w_tick;
                        end else begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef BIG_DATA_SCHED_OVERRUN_CNT_EN
    logic [15:0] r_ovr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovr <= '0;
        end else if (w_arm) begin
            r_ovr <= '0;
        end else if (!abort && w_drop && (r_ovr != 16'hFFFF)) begin
            r_ovr <= r_ovr + 16'd1;
        end
    end

    assign overrun_cnt = r_ovr;
`endif

    assign addr_valid  = r_valid;
    assign addr_x      = r_x;
    assign addr_y      = r_y;
    assign addr_flat   = r_flat;
    assign frame_start = r_fstart;
    assign frame_done  = r_fdone;
    assign frames_done = r_frames;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
